// File: rtl/r2b_converter.sv
// rtl/r2b_converter.sv - row-to-block converter: buffers one strip of row segments, emits square blocks
module r2b_converter #(
    parameter int WIDTH       = 16,
    parameter int BLOCK_SIZE  = 2,
    parameter int NUM_CORES_V = 2,
    parameter int NUM_CORES_H = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   in_valid,
    output logic                                   in_ready,
    input  logic [WIDTH*BLOCK_SIZE-1:0]            in_data,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [WIDTH*BLOCK_SIZE*BLOCK_SIZE-1:0] out_data,
    output logic                                   out_last,
    output logic                                   strip_done
);

    localparam int ROW = NUM_CORES_V * BLOCK_SIZE;
    localparam int COL = NUM_CORES_H * BLOCK_SIZE;

    localparam int RW = (ROW > 1) ? $clog2(ROW) : 1;
    localparam int CW = (NUM_CORES_H > 1) ? $clog2(NUM_CORES_H) : 1;
    localparam int VW = (NUM_CORES_V > 1) ? $clog2(NUM_CORES_V) : 1;
    localparam int HW = CW;

    localparam logic [RW-1:0] R_LAST = RW'(ROW - 1);
    localparam logic [CW-1:0] C_LAST = CW'(NUM_CORES_H - 1);
    localparam logic [VW-1:0] V_LAST = VW'(NUM_CORES_V - 1);
    localparam logic [HW-1:0] H_LAST = HW'(NUM_CORES_H - 1);

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] buf_q [ROW][COL];

    logic [RW-1:0] r_q, r_d;
    logic [CW-1:0] c_q, c_d;
    logic [VW-1:0] v_q, v_d;
    logic [HW-1:0] h_q, h_d;

    logic strip_done_q, strip_done_d;

    logic in_fire;
    logic out_fire;
    logic last_in;
    logic last_out;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign last_in  = (r_q == R_LAST) && (c_q == C_LAST);
    assign last_out = (v_q == V_LAST) && (h_q == H_LAST);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: FILL until the last segment lands, DRAIN until the last block leaves
    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (in_fire && last_in)   state_d = DRAIN;
            DRAIN:   if (out_fire && last_out) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    // Outputs decoded from state only, so neither valid depends on the opposite ready
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        case (state_q)
            FILL: begin
                in_ready = 1'b1;
            end
            DRAIN: begin
                out_valid = 1'b1;
                out_last  = last_out;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    // Counter next values: segment inner / row outer on input, block column inner / block row outer on output
    always_comb begin
        r_d          = r_q;
        c_d          = c_q;
        v_d          = v_q;
        h_d          = h_q;
        strip_done_d = 1'b0;
        if (in_fire) begin
            if (c_q == C_LAST) begin
                c_d = '0;
                r_d = (r_q == R_LAST) ? '0 : r_q + 1'b1;
            end else begin
                c_d = c_q + 1'b1;
            end
        end
        if (out_fire) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
            strip_done_d = last_out;
        end
    end

    // Counter and strip_done registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q          <= '0;
            c_q          <= '0;
            v_q          <= '0;
            h_q          <= '0;
            strip_done_q <= 1'b0;
        end else begin
            r_q          <= r_d;
            c_q          <= c_d;
            v_q          <= v_d;
            h_q          <= h_d;
            strip_done_q <= strip_done_d;
        end
    end

    assign strip_done = strip_done_q;

    // Strip buffer: each accepted segment lands in row r, columns c*BLOCK_SIZE .. c*BLOCK_SIZE+BLOCK_SIZE-1
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < ROW; r++) begin
                for (int col = 0; col < COL; col++) begin
                    buf_q[r][col] <= '0;
                end
            end
        end else if (in_fire) begin
            for (int r = 0; r < ROW; r++) begin
                for (int col = 0; col < COL; col++) begin
                    if ((r_q == RW'(r)) && (c_q == CW'(col / BLOCK_SIZE))) begin
                        buf_q[r][col] <= in_data[(col % BLOCK_SIZE)*WIDTH +: WIDTH];
                    end
                end
            end
        end
    end

    // Block select: buffer is stable during DRAIN, so the mux output holds until the transfer
    always_comb begin
        out_data = '0;
        for (int v = 0; v < NUM_CORES_V; v++) begin
            for (int h = 0; h < NUM_CORES_H; h++) begin
                if ((v_q == VW'(v)) && (h_q == HW'(h))) begin
                    for (int i = 0; i < BLOCK_SIZE; i++) begin
                        for (int j = 0; j < BLOCK_SIZE; j++) begin
                            out_data[(i*BLOCK_SIZE+j)*WIDTH +: WIDTH] =
                                buf_q[v*BLOCK_SIZE+i][h*BLOCK_SIZE+j];
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_r2b_converter.sv
// tb/tb_r2b_converter.sv - directed self-checking bench for r2b_converter
module tb_r2b_converter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready, out_last, strip_done;
    logic [31:0]  in_data;
    logic [63:0]  out_data;

    logic         p_in_valid, p_in_ready, p_out_valid, p_out_ready, p_out_last, p_strip_done;
    logic [31:0]  p_in_data;
    logic [127:0] p_out_data;

    logic [63:0]  cap [8];

    int checks   = 0;
    int failures = 0;

    r2b_converter #(.WIDTH(16), .BLOCK_SIZE(2), .NUM_CORES_V(2), .NUM_CORES_H(4)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .strip_done(strip_done)
    );

    r2b_converter #(.WIDTH(8), .BLOCK_SIZE(4), .NUM_CORES_V(1), .NUM_CORES_H(2)) u_dut_p (
        .clk(clk), .rst(rst),
        .in_valid(p_in_valid), .in_ready(p_in_ready), .in_data(p_in_data),
        .out_valid(p_out_valid), .out_ready(p_out_ready), .out_data(p_out_data),
        .out_last(p_out_last), .strip_done(p_strip_done)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] beat(input int r, input int c, input int off);
        logic [31:0] d;
        for (int k = 0; k < 2; k++) d[k*16 +: 16] = 16'(r*16 + c*2 + k + off);
        return d;
    endfunction

    function automatic logic [63:0] exp_blk(input int b, input int off);
        logic [63:0] d;
        int v, h;
        v = b / 4;
        h = b % 4;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                d[(i*2+j)*16 +: 16] = 16'((v*2+i)*16 + h*2 + j + off);
        return d;
    endfunction

    task automatic send_strip(input int off, input bit gaps, input bit lockout);
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (gaps) begin
                    int n;
                    n = $urandom_range(0, 2);
                    repeat (n) begin
                        @(negedge clk);
                        in_valid = 1'b0;
                    end
                end
                @(negedge clk);
                in_valid = 1'b1;
                in_data  = beat(r, c, off);
                #1;
                chk("fill_in_ready", in_ready, 1);
                chk("fill_out_valid", out_valid, 0);
            end
        end
        @(negedge clk);
        in_valid = lockout;
        in_data  = lockout ? 32'hFFFF_FFFF : 32'h0;
        #1;
        chk("valid_latency", out_valid, 1);
    endtask

    task automatic recv_strip(input int off, input bit bp, input bit lockout, input int nblk);
        int b;
        int cyc;
        b   = 0;
        cyc = 0;
        while (b < nblk && cyc < 200) begin
            if (cyc > 0) begin
                @(negedge clk);
                in_valid = lockout;
                in_data  = lockout ? 32'hFFFF_FFFF : 32'h0;
                #1;
            end
            out_ready = bp ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
            chk("drain_out_valid", out_valid, 1);
            chk("drain_in_ready", in_ready, 0);
            chk("drain_strip_done", strip_done, 0);
            chk("drain_out_data", out_data, exp_blk(b, off));
            chk("drain_out_last", out_last, (b == 7));
            if (out_ready) begin
                cap[b] = out_data;
                b++;
            end
            cyc++;
        end
        chk("drain_count", b, nblk);
        if (nblk == 8) begin
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b0;
            #1;
            chk("done_pulse", strip_done, 1);
            chk("done_in_ready", in_ready, 1);
            chk("done_out_valid", out_valid, 0);
            chk("done_out_last", out_last, 0);
            @(negedge clk);
            #1;
            chk("done_pulse_end", strip_done, 0);
        end
    endtask

    task automatic reset_check(input string tag);
        @(negedge clk);
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        p_in_valid  = 1'b0;
        p_out_ready = 1'b0;
        rst         = 1'b1;
        #1;
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_last"}, out_last, 0);
        chk({tag, "_strip_done"}, strip_done, 0);
        chk({tag, "_out_data"}, out_data, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
        out_ready   = 1'b0;
        p_in_valid  = 1'b0;
        p_in_data   = '0;
        p_out_ready = 1'b0;
        reset_check("reset");

        // basic strip
        send_strip(0, 1'b0, 1'b0);
        recv_strip(0, 1'b0, 1'b0, 8);
        chk("basic_blk0", cap[0], 64'h0011_0010_0001_0000);
        chk("basic_blk1", cap[1], 64'h0013_0012_0003_0002);
        chk("basic_blk4", cap[4], 64'h0031_0030_0021_0020);
        chk("basic_blk7", cap[7], 64'h0037_0036_0027_0026);

        // back-to-back second strip with backpressure
        send_strip(32'h100, 1'b0, 1'b0);
        recv_strip(32'h100, 1'b1, 1'b0, 8);
        chk("b2b_blk0", cap[0], 64'h0111_0110_0101_0100);

        // input gaps and drain lockout
        send_strip(32'h20, 1'b1, 1'b1);
        recv_strip(32'h20, 1'b0, 1'b1, 8);

        // reset mid-FILL
        for (int n = 0; n < 7; n++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = beat(n / 4, n % 4, 32'h200);
        end
        reset_check("rst_fill");
        send_strip(32'h300, 1'b0, 1'b0);
        recv_strip(32'h300, 1'b0, 1'b0, 8);

        // reset mid-DRAIN
        send_strip(32'h400, 1'b0, 1'b0);
        recv_strip(32'h400, 1'b0, 1'b0, 3);
        reset_check("rst_drain");
        send_strip(32'h500, 1'b0, 1'b0);
        recv_strip(32'h500, 1'b1, 1'b0, 8);

        // parameter variant: BLOCK_SIZE=4, NUM_CORES_V=1, NUM_CORES_H=2, WIDTH=8
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 2; c++) begin
                @(negedge clk);
                p_in_valid = 1'b1;
                for (int k = 0; k < 4; k++) p_in_data[k*8 +: 8] = 8'(r*8 + c*4 + k);
                #1;
                chk("p_in_ready", p_in_ready, 1);
            end
        end
        @(negedge clk);
        p_in_valid = 1'b0;
        #1;
        chk("p_out_valid", p_out_valid, 1);
        chk("p_blk0", p_out_data, 128'h1b1a1918_13121110_0b0a0908_03020100);
        chk("p_last0", p_out_last, 0);
        p_out_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("p_blk1", p_out_data, 128'h1f1e1d1c_17161514_0f0e0d0c_07060504);
        chk("p_last1", p_out_last, 1);
        @(negedge clk);
        p_out_ready = 1'b0;
        #1;
        chk("p_done", p_strip_done, 1);
        chk("p_in_ready_after", p_in_ready, 1);
        chk("p_out_valid_after", p_out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
